// File: rtl/addsub_pkg.sv
// Shared types and defaults for the chunked sequential adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package addsub_pkg;

  localparam int W_DEF = 4;
  localparam int K_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_seq_if.sv
// Operand/result bus of addsub_seq: input handshake with A/B/M, output handshake with S and flags.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface addsub_seq_if import addsub_pkg::*; #(
  parameter int W = W_DEF,
  parameter int K = K_DEF
) ();

  localparam int N = W * K;

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         M;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         C;
  logic         V;
  logic         Z;
  logic         NEG;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, A, B, M, out_ready,
    input  in_ready, out_valid, S, C, V, Z, NEG
  );

  // Arithmetic block side.
  modport slave (
    input  in_valid, A, B, M, out_ready,
    output in_ready, out_valid, S, C, V, Z, NEG
  );

endinterface

// File: rtl/addsub_chunk.sv
// W-bit ripple add of a + (b ^ m) + ci built from per-bit propagate/generate cells.
// Latency: purely combinational.
// Backpressure: none (no state).
module addsub_chunk import addsub_pkg::*; #(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         cmsb
);

  logic [W-1:0] bx;
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic [W:0]   c;

  // Subtract inverts B here; the +1 arrives through the carry chain.
  assign bx   = b ^ {W{m}};
  assign p    = a ^ bx;
  assign g    = a & bx;
  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_cell
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  assign sum  = p ^ c[W-1:0];
  assign co   = c[W];
  // Carry into the top bit of this chunk; on the last chunk it is the carry into bit N-1.
  assign cmsb = c[W-1];

endmodule

// File: rtl/addsub_seq.sv
// N=W*K bit add/subtract processed one W-bit chunk per cycle, LSB chunk first, with C/V/Z/NEG flags.
// Latency: exactly K cycles from input handshake to out_valid; one op per K+2 cycles at best.
// Backpressure: in_ready only in IDLE; DONE holds S and flags frozen until out_ready.
module addsub_seq import addsub_pkg::*; #(
  parameter int W = W_DEF,
  parameter int K = K_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_seq_if.slave  bus
);

  localparam int N  = W * K;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST = IW'(K - 1);

  state_t         state;
  state_t         state_nxt;

  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           m_q;
  logic [N-1:0]   s_q;
  logic           cy_q;
  logic           c_q;
  logic           v_q;
  logic [IW-1:0]  idx_q;

  logic [W-1:0]   a_ch;
  logic [W-1:0]   b_ch;
  logic [W-1:0]   sum_ch;
  logic           co_ch;
  logic           cmsb_ch;
  logic           accept;
  logic           last;

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (idx_q == LAST);

  assign a_ch = a_q[int'(idx_q) * W +: W];
  assign b_ch = b_q[int'(idx_q) * W +: W];

  addsub_chunk #(.W(W)) u_chunk (
    .a    (a_ch),
    .b    (b_ch),
    .m    (m_q),
    .ci   (cy_q),
    .sum  (sum_ch),
    .co   (co_ch),
    .cmsb (cmsb_ch)
  );

  // State register; reset lands in IDLE without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: accept in IDLE, walk K chunks in RUN, wait for the consumer in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, then fold one chunk per RUN cycle into S and the carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      m_q   <= 1'b0;
      s_q   <= '0;
      cy_q  <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      idx_q <= '0;
    end else if (accept) begin
      a_q   <= bus.A;
      b_q   <= bus.B;
      m_q   <= bus.M;
      cy_q  <= bus.M;
      idx_q <= '0;
    end else if (state == RUN) begin
      s_q[int'(idx_q) * W +: W] <= sum_ch;
      cy_q <= co_ch;
      if (last) begin
        c_q <= co_ch;
        v_q <= cmsb_ch ^ co_ch;
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.S         = s_q;
  assign bus.C         = c_q;
  assign bus.V         = v_q;
  // Z and NEG follow the S register directly, so they track it through reset as well.
  assign bus.Z         = (s_q == '0);
  assign bus.NEG       = s_q[N-1];

endmodule

// File: tb/tb_addsub_seq.sv
// Directed checks of addsub_seq at W=4,K=4 plus a randomized W/K sweep against a reference model.
// Latency: verifies the K-cycle accept-to-out_valid latency and the K+2 issue period.
// Backpressure: holds out_ready low in DONE and checks that outputs stay frozen.
module tb_addsub_seq;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic sw_rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic sw_all;

  always #5 clk = ~clk;

  // Free-running cycle count used to measure issue spacing.
  always @(posedge clk) cyc <= cyc + 1;

  addsub_seq_if #(.W(W_DEF), .K(K_DEF)) bus ();
  addsub_seq #(.W(W_DEF), .K(K_DEF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] s, input logic c, input logic v,
                         input logic z, input logic neg);
    chk({tag, "_S"},   32'(bus.S),   32'(s));
    chk({tag, "_C"},   32'(bus.C),   32'(c));
    chk({tag, "_V"},   32'(bus.V),   32'(v));
    chk({tag, "_Z"},   32'(bus.Z),   32'(z));
    chk({tag, "_NEG"}, 32'(bus.NEG), 32'(neg));
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge with garbage on the inputs.
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.A = a;
    bus.B = b;
    bus.M = m;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.A = ~a;
    bus.B = ~b;
    bus.M = ~m;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  // Handshake the result and confirm the block is back in IDLE one cycle later.
  task automatic release_op(input string tag);
    chk({tag, "_in_ready_done"}, 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic full_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m,
                         input logic [15:0] s, input logic c, input logic v, input logic z, input logic neg);
    start_op(tag, a, b, m);
    wait_done(tag, 4);
    chk_res(tag, s, c, v, z, neg);
    release_op(tag);
  endtask

  // Randomized sweep over W in {1,4,8} and K in {1,3,4}, each with its own DUT.
  for (genvar g = 0; g < 9; g++) begin : sweep
    localparam int GW = (g / 3 == 0) ? 1 : ((g / 3 == 1) ? 4 : 8);
    localparam int GK = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 3 : 4);
    localparam int GN = GW * GK;

    bit done = 1'b0;

    addsub_seq_if #(.W(GW), .K(GK)) sbus ();
    addsub_seq #(.W(GW), .K(GK)) sdut (.clk(clk), .rst_n(sw_rst_n), .bus(sbus.slave));

    initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [GN-1:0] a;
      logic [GN-1:0] b;
      logic [GN-1:0] bb;
      logic [GN-1:0] s;
      logic [GN:0]   full;
      logic          m;
      logic          c;
      logic          v;
      int            lat;
      sbus.in_valid  = 1'b0;
      sbus.out_ready = 1'b0;
      sbus.A = '0;
      sbus.B = '0;
      sbus.M = 1'b0;
      wait (sw_rst_n === 1'b1);
      for (int t = 0; t < 12; t++) begin
        @(negedge clk);
        ra = $urandom();
        rb = $urandom();
        a = ra[GN-1:0];
        b = rb[GN-1:0];
        m = 1'($urandom_range(1, 0));
        if (t == 0) begin
          a = '1;
          b = GN'(1);
          m = 1'b0;
        end else if (t == 1) begin
          a = '0;
          a[GN-1] = 1'b1;
          b = GN'(1);
          m = 1'b1;
        end
        bb   = m ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (GN+1)'(m);
        s    = full[GN-1:0];
        c    = full[GN];
        v    = (a[GN-1] == bb[GN-1]) && (s[GN-1] != a[GN-1]);
        sbus.A = a;
        sbus.B = b;
        sbus.M = m;
        sbus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        sbus.in_valid = 1'b0;
        sbus.A = ~a;
        sbus.B = ~b;
        @(negedge clk);
        lat = 0;
        while (!sbus.out_valid && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        checks++;
        assert ({sbus.out_valid, sbus.S, sbus.C, sbus.V, sbus.Z, sbus.NEG} === {1'b1, s, c, v, (s == '0), s[GN-1]}
                && lat == GK) else begin
          errors++;
          $error("FAIL sweep_W%0d_K%0d op%0d: observed S=%0h C=%0b V=%0b Z=%0b NEG=%0b lat=%0d expected S=%0h C=%0b V=%0b Z=%0b NEG=%0b lat=%0d",
                 GW, GK, t, sbus.S, sbus.C, sbus.V, sbus.Z, sbus.NEG, lat, s, c, v, (s == '0), s[GN-1], GK);
        end
        sbus.out_ready = 1'b1;
        @(negedge clk);
        sbus.out_ready = 1'b0;
      end
      done = 1'b1;
    end
  end

  assign sw_all = sweep[0].done & sweep[1].done & sweep[2].done & sweep[3].done & sweep[4].done
                & sweep[5].done & sweep[6].done & sweep[7].done & sweep[8].done;

  initial begin
    logic [15:0] s_hold;
    int          t0;
    int          t1;
    int          n;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.M = 1'b0;
    rst_n    = 1'b1;
    sw_rst_n = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    sw_rst_n = 1'b1;
    @(negedge clk);

    // Plain add; inputs are scrambled during RUN by start_op.
    full_op("add", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0);
    // Subtract with borrow, then signed overflow on subtract.
    full_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    full_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
    // Signed overflow on add, then unsigned wrap to zero.
    full_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    full_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);

    // Backpressure: DONE held for 5 cycles with outputs frozen.
    start_op("bp", 16'h00FF, 16'h0001, 1'b0);
    wait_done("bp", 4);
    s_hold = bus.S;
    chk("bp_S_first", 32'(s_hold), 32'h0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_S_stable", 32'(bus.S), 32'h0100);
      chk("bp_flags", 32'({bus.C, bus.V, bus.Z, bus.NEG}), 32'd0);
    end
    release_op("bp");

    // Back-to-back issue with both sides always ready: one accept per K+2 cycles.
    bus.A = 16'h0001;
    bus.B = 16'h0002;
    bus.M = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 16; i++) begin
      if (bus.in_ready) begin
        if (t0 < 0) t0 = cyc;
        else if (t1 < 0) t1 = cyc;
      end
      if (bus.out_valid) chk("b2b_S", 32'(bus.S), 32'h0003);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("b2b_period", 32'(t1 - t0), 32'd6);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_drain_valid", 32'(bus.out_valid), 32'd1);
    release_op("b2b");

    // Reset in the middle of RUN, observed without a clock edge.
    start_op("mid_rst", 16'hAAAA, 16'h5555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk_res("mid_rst", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    full_op("post_rst", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0, 1'b0);

    n = 0;
    while (!sw_all && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_done", 32'(sw_all), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_seq.md
# addsub_seq

Multi-cycle, parametrised two's-complement adder/subtractor for operands of `N = W*K` bits. It processes one W-bit chunk per clock, least-significant chunk first, and propagates the carry between chunks in a register. This lets wide datapaths reuse a narrow carry chain. It sits between operand registers and the result bus, with valid/ready handshakes on both sides. It reports carry, signed overflow, zero and negative flags for the full N-bit result.

## Interface
- `W`, default 4: chunk width, the bits added per cycle, W ≥ 1.
- `K`, default 4: number of chunks, K ≥ 1; operand width `N = W*K`.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  operands and mode are presented.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `A`, `B`  in  N  operands, sampled on input handshake.
- `M`  in  1  mode: 0 = A+B, 1 = A−B (A + ~B + 1).
- `out_valid`  out  1  result and flags valid; high only in DONE.
- `out_ready`  in  1  consumer accepts result.
- `S`  out  N  result.
- `C`  out  1  carry out of bit N−1 (subtract: 1 = no borrow).
- `V`  out  1  signed overflow = carry into bit N−1 XOR carry out of bit N−1.
- `Z`  out  1  S == 0.
- `NEG`  out  1  S[N−1].

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch A, B, M into internal registers; carry register ← M; chunk index ← 0; go to RUN.
- RUN: each cycle processes chunk i (bits `[i*W +: W]`):
  - sum = A_i + (B_i ^ {W{M}}) + carry.
  - S chunk i ← sum[W−1:0]; carry ← carry out.
  - When i == K−1: C ← carry out; V ← carry into MSB XOR carry out; go to DONE. Otherwise i ← i+1.
- DONE:
  - `out_valid`=1.
  - S, C, V, Z, NEG are held stable.
  - On `out_ready`: go to IDLE.
- Z and NEG are derived combinationally from the S register.
- Inputs are ignored outside the IDLE handshake. A, B and M may change freely once accepted.
- S, C and V keep their last values in IDLE. They are meaningful only while `out_valid`=1.
- Reset (`rst_n`=0), at any time including mid-RUN:
  - state → IDLE.
  - S, C, V, index and carry register → 0.
  - `in_ready`=1 and `out_valid`=0 immediately (asynchronous).
  - Z=1, NEG=0.
  - The partial operation is discarded. The first operation after reset is correct.
- Arithmetic is modulo 2^N. No saturation.

## Timing
- Accept edge e0 → RUN on edges e1…eK → `out_valid` rises after edge eK. Latency from acceptance to `out_valid` is exactly K cycles.
- K=1 degenerates to a single RUN cycle.
- Throughput: at most one operation per K+2 cycles (IDLE, K×RUN, DONE).
- There is no accept in DONE. `in_ready` is low in RUN and DONE, including the DONE cycle in which `out_ready` handshakes; `in_ready` rises the following cycle.
- `out_ready` held low keeps DONE indefinitely, with outputs frozen.
- `out_ready` high while in IDLE or RUN has no effect.

## Structure
- Package `addsub_pkg`: state encoding constants (IDLE=0, RUN=1, DONE=2) and default W/K values.
- Sub-module `addsub_chunk` (combinational):
  - inputs: W-bit a, b, mode m, carry-in.
  - outputs: W-bit sum, carry-out, carry-into-MSB.
  - implemented as a W-bit ripple chain of per-bit propagate/generate cells.
- Top level:
  - FSM, chunk index counter (`$clog2(K)` bits, minimum 1).
  - Carry register, operand registers, S register.
  - Chunk selection by indexed part-select.

## Test plan
- W=4, K=4: A=0x1234, B=0x0FCD, M=0 → S=0x2201, C=0, V=0, Z=0, NEG=0; `out_valid` rises exactly 4 cycles after accept.
- A=0x0005, B=0x0007, M=1 → S=0xFFFE, C=0, V=0, NEG=1. Then A=0x8000, B=0x0001, M=1 → S=0x7FFF, C=1, V=1.
- A=0x7FFF, B=0x0001, M=0 → S=0x8000, V=1, C=0, NEG=1. Then A=0xFFFF, B=0x0001, M=0 → S=0x0000, C=1, Z=1, V=0.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, S and flags stable and `in_ready`=0. Raise `out_ready` → IDLE next cycle. Back-to-back ops are accepted every K+2 cycles.
- Change A, B and M during RUN → result reflects the latched values only.
- Assert `rst_n`=0 mid-RUN (index=2) → outputs zero, `in_ready`=1 with no clock edge needed. The next op (0x1234+0x0FCD) → 0x2201.
- Parameter sweep W∈{1,4,8}, K∈{1,3,4}: random A, B, M vs reference model, N-bit result plus C/V/Z/NEG.
